// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: read latency, access owner, arbiter state and read tag.
package vram_pkg;

    localparam int RD_LAT = 2;

    typedef enum logic {
        OWN_AXI = 1'b0,
        OWN_VID = 1'b1
    } owner_e;

    typedef enum logic {
        VID_PRI  = 1'b0,
        AXI_TURN = 1'b1
    } arb_state_e;

    // zero marks an out-of-range AXI read whose data must be returned as 0
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   zero;
    } rd_tag_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Tracks each granted read for RD_LAT cycles so its data can be routed to the right owner.
module vram_rd_tag_pipe
    import vram_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_issue,
    output rd_tag_t tag_done
);

    rd_tag_t tag_p [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= tag_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign tag_done = tag_p[RD_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between an AXI register path and a video glyph fetcher.
// Define VRAM_ARB_STARVE_GUARD_EN to let a starved AXI request win after STARVE_LIMIT video grants.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 601,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              axi_req,
    input  logic              axi_we,
    input  logic [ADDR_W-1:0] axi_addr,
    input  logic [31:0]       axi_wdata,
    input  logic [3:0]        axi_wstrb,
    output logic              axi_ack,
    output logic              axi_rvalid,
    output logic [31:0]       axi_rdata,
    output logic              axi_err,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_rvalid,
    output logic [31:0]       vid_rdata,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    input  logic [31:0]       bram_dout
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must lie in 1..7 for the 3-bit starve counter");
    end

    arb_state_e  state;
    logic        axi_grant;
    logic        vid_grant;
    logic        axi_oob;
    rd_tag_t     tag_issue;
    rd_tag_t     tag_done;
    logic [31:0] axi_rdata_last;
    logic [31:0] vid_rdata_last;

    assign axi_oob = 32'(axi_addr) >= 32'(DEPTH);

    // Grants are gated by reset so every request-side output reads 0 while reset is held.
    always_comb begin
        axi_grant = 1'b0;
        vid_grant = 1'b0;
        if (S_AXI_ARESETN) begin
            if (axi_req && (!vid_req || state == AXI_TURN)) begin
                axi_grant = 1'b1;
            end else if (vid_req) begin
                vid_grant = 1'b1;
            end
        end
    end

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt;
    logic [2:0] starve_next;
    arb_state_e state_next;

    always_comb begin
        starve_next = starve_cnt;
        state_next  = state;
        if (axi_grant || !axi_req) begin
            starve_next = '0;
        end else if (vid_grant && starve_cnt != 3'd7) begin
            starve_next = starve_cnt + 3'd1;
        end
        case (state)
            VID_PRI:  if (vid_grant && axi_req && starve_next >= STARVE_MAX) state_next = AXI_TURN;
            AXI_TURN: if (axi_grant) state_next = VID_PRI;
            default:  state_next = VID_PRI;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state      <= VID_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end
`else
    assign state = VID_PRI;
`endif

    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 4'h0;
        bram_addr = vid_addr;
        bram_din  = axi_wdata;
        if (axi_grant) begin
            bram_addr = axi_addr;
            if (!axi_oob) begin
                bram_en = 1'b1;
                if (axi_we) bram_we = axi_wstrb;
            end
        end else if (vid_grant) begin
            bram_en = 1'b1;
        end
    end

    always_comb begin
        tag_issue       = '0;
        tag_issue.valid = (axi_grant && !axi_we) || vid_grant;
        tag_issue.owner = vid_grant ? OWN_VID : OWN_AXI;
        tag_issue.zero  = axi_grant && axi_oob;
    end

    assign axi_ack = axi_grant;
    assign axi_err = axi_grant && axi_oob;
    assign vid_ack = vid_grant;

    // ---- grant cycle N -> response cycle N+RD_LAT ----
    vram_rd_tag_pipe u_tag_pipe (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .tag_issue (tag_issue),
        .tag_done  (tag_done)
    );

    assign axi_rvalid = S_AXI_ARESETN && tag_done.valid && tag_done.owner == OWN_AXI;
    assign vid_rvalid = S_AXI_ARESETN && tag_done.valid && tag_done.owner == OWN_VID;

    always_comb begin
        axi_rdata = axi_rdata_last;
        vid_rdata = vid_rdata_last;
        if (!S_AXI_ARESETN) begin
            axi_rdata = '0;
            vid_rdata = '0;
        end else begin
            if (axi_rvalid) axi_rdata = tag_done.zero ? 32'd0 : bram_dout;
            if (vid_rvalid) vid_rdata = bram_dout;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            axi_rdata_last <= '0;
            vid_rdata_last <= '0;
        end else begin
            if (axi_rvalid) axi_rdata_last <= axi_rdata;
            if (vid_rvalid) vid_rdata_last <= vid_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed requests push expected reads, a monitor checks rvalid responses.
module tb_vram_arbiter;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int EXP_OFF = 4;
`else
    localparam int EXP_OFF = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        axi_req, axi_we;
    logic [9:0]  axi_addr;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_ack, axi_rvalid, axi_err;
    logic [31:0] axi_rdata;
    logic        vid_req;
    logic [9:0]  vid_addr;
    logic        vid_ack, vid_rvalid;
    logic [31:0] vid_rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din, bram_dout;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    vram_arbiter dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .axi_req       (axi_req),
        .axi_we        (axi_we),
        .axi_addr      (axi_addr),
        .axi_wdata     (axi_wdata),
        .axi_wstrb     (axi_wstrb),
        .axi_ack       (axi_ack),
        .axi_rvalid    (axi_rvalid),
        .axi_rdata     (axi_rdata),
        .axi_err       (axi_err),
        .vid_req       (vid_req),
        .vid_addr      (vid_addr),
        .vid_ack       (vid_ack),
        .vid_rvalid    (vid_rvalid),
        .vid_rdata     (vid_rdata),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_dout     (bram_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: word 5 starts at 0, every other word at 0xA5000000 | addr; two-cycle read latency.
    logic [31:0] mem [1024];
    logic [1023:0] wr;
    logic [31:0] rd_p0, rd_p1, cur_w, new_w;

    function automatic logic [31:0] init_word(input logic [9:0] a);
        return (a == 10'd5) ? 32'd0 : (32'hA500_0000 | 32'(a));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) wr <= '0;
        if (bram_en) begin
            cur_w = wr[bram_addr] ? mem[bram_addr] : init_word(bram_addr);
            new_w = cur_w;
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) new_w[8*b +: 8] = bram_din[8*b +: 8];
            end
            rd_p0 <= cur_w;
            if (|bram_we) begin
                mem[bram_addr] <= new_w;
                wr[bram_addr]  <= 1'b1;
            end
        end
        rd_p1 <= rd_p0;
    end
    assign bram_dout = rd_p1;

    typedef struct {
        bit          vid;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic expect_rd(input bit vid, input logic [31:0] d);
        exp_q.push_back('{vid, d, cyc + 2});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_rvalid: rvalid absent, required vid=%0b data %h at cycle %0d", mon_e.vid, mon_e.data, mon_e.due);
        end
        if (axi_rvalid || vid_rvalid) begin
            if (axi_rvalid && vid_rvalid) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dual_rvalid: both rvalid high at cycle %0d, required at most one", cyc);
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rvalid: axi=%0b vid=%0b at cycle %0d, required none", axi_rvalid, vid_rvalid, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("rvalid_owner_vid", 32'(vid_rvalid), 32'(mon_e.vid));
                check("rdata", vid_rvalid ? vid_rdata : axi_rdata, mon_e.data);
                check("rvalid_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_ctl"}, 32'({axi_ack, axi_rvalid, axi_err, vid_ack, vid_rvalid, bram_en, bram_we}), 32'd0);
        check({nm, "_axi_rdata"}, axi_rdata, 32'd0);
        check({nm, "_vid_rdata"}, vid_rdata, 32'd0);
    endtask

    // Called just after a clock edge; leaves just after the edge that ends the ack cycle.
    task automatic axi_op(input bit we, input logic [9:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit err, input logic [31:0] rd_exp);
        int waited;
        waited    = 0;
        axi_req   = 1'b1;
        axi_we    = we;
        axi_addr  = addr;
        axi_wdata = wdata;
        axi_wstrb = wstrb;
        at_neg();
        while (!axi_ack && waited < 16) begin
            tick();
            at_neg();
            waited++;
        end
        if (!axi_ack) begin
            n_cmp++;
            n_bad++;
            $display("FAIL axi_ack_timeout: no ack after %0d cycles, required ack", waited);
        end else begin
            check("axi_err", 32'(axi_err), 32'(err));
            check("bram_en", 32'(bram_en), 32'(!err));
            check("bram_we", 32'(bram_we), (we && !err) ? 32'(wstrb) : 32'd0);
            if (!err) check("bram_addr", 32'(bram_addr), 32'(addr));
            if (we && !err) check("bram_din", bram_din, wdata);
            if (!we) expect_rd(1'b0, rd_exp);
        end
        tick();
        axi_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int off;
        rst_n     = 1'b0;
        axi_req   = 1'b1;
        axi_we    = 1'b0;
        axi_addr  = 10'd9;
        axi_wdata = 32'd0;
        axi_wstrb = 4'h0;
        vid_req   = 1'b1;
        vid_addr  = 10'd7;
        idle(3);
        at_neg();
        check_quiet("reset_state");

        // Simultaneous requests out of reset: video first, AXI next cycle.
        tick();
        rst_n = 1'b1;
        at_neg();
        check("tie_vid_ack", 32'(vid_ack), 32'd1);
        check("tie_axi_ack", 32'(axi_ack), 32'd0);
        check("tie_bram_addr", 32'(bram_addr), 32'd7);
        if (vid_ack) expect_rd(1'b1, 32'hA500_0007);
        tick();
        vid_req = 1'b0;
        at_neg();
        check("tie_axi_ack_c1", 32'(axi_ack), 32'd1);
        check("tie_bram_addr_c1", 32'(bram_addr), 32'd9);
        if (axi_ack) expect_rd(1'b0, 32'hA500_0009);
        tick();
        axi_req = 1'b0;
        idle(4);

        // Byte-strobed writes followed by reads.
        axi_op(1'b1, 10'd5, 32'hDEAD_BEEF, 4'h3, 1'b0, 32'd0);
        axi_op(1'b0, 10'd5, 32'd0, 4'h0, 1'b0, 32'h0000_BEEF);
        axi_op(1'b1, 10'd8, 32'h1122_3344, 4'hC, 1'b0, 32'd0);
        axi_op(1'b0, 10'd8, 32'd0, 4'h0, 1'b0, 32'h1122_0008);
        idle(4);

        // Address range boundary.
        axi_op(1'b0, 10'd601, 32'd0, 4'h0, 1'b1, 32'd0);
        axi_op(1'b1, 10'd700, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0);
        axi_op(1'b0, 10'd600, 32'd0, 4'h0, 1'b0, 32'hA500_0258);
        idle(4);

        // Continuous video traffic against a pending AXI read, twice.
        for (int r = 0; r < 2; r++) begin
            off      = -1;
            vid_req  = 1'b1;
            vid_addr = 10'd7;
            axi_req  = 1'b1;
            axi_we   = 1'b0;
            axi_addr = 10'd3;
            for (int k = 0; k < 10; k++) begin
                if (k == 8) vid_req = 1'b0;
                at_neg();
                if (vid_ack) expect_rd(1'b1, 32'hA500_0007);
                if (axi_ack) begin
                    if (off < 0) off = k;
                    check("starve_vid_ack_low", 32'(vid_ack), 32'd0);
                    expect_rd(1'b0, 32'hA500_0003);
                end
                tick();
                if (off >= 0) axi_req = 1'b0;
            end
            vid_req = 1'b0;
            axi_req = 1'b0;
            check("starve_ack_offset", 32'(off), 32'(EXP_OFF));
            idle(4);
        end

        // Back-to-back video reads with no bubbles.
        vid_req = 1'b1;
        for (int a = 10; a < 13; a++) begin
            vid_addr = 10'(a);
            at_neg();
            check("burst_vid_ack", 32'(vid_ack), 32'd1);
            if (vid_ack) expect_rd(1'b1, 32'hA500_0000 | 32'(a));
            tick();
        end
        vid_req = 1'b0;
        idle(4);
        at_neg();
        check("axi_rdata_hold", axi_rdata, 32'hA500_0003);
        check("vid_rdata_hold", vid_rdata, 32'hA500_000C);

        // Reset one cycle after a video grant drops the read.
        tick();
        vid_req  = 1'b1;
        vid_addr = 10'd7;
        at_neg();
        check("pre_reset_vid_ack", 32'(vid_ack), 32'd1);
        tick();
        vid_req  = 1'b0;
        rst_n    = 1'b0;
        axi_req  = 1'b1;
        axi_we   = 1'b0;
        axi_addr = 10'd4;
        at_neg();
        check_quiet("mid_reset_c1");
        tick();
        at_neg();
        check_quiet("mid_reset_c2");
        tick();
        rst_n   = 1'b1;
        axi_req = 1'b0;
        idle(5);

        at_neg();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, VRAM word-address width.
REQ-002 Parameter DEPTH, default 601, number of valid 32-bit VRAM words.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive video grants allowed while AXI waits.
REQ-004 S_AXI_ACLK  in  1  sole clock; one clock; reset is synchronous and active-low.
REQ-005 S_AXI_ARESETN  in  1  synchronous active-low reset.
REQ-006 axi_req  in  1  AXI-side access request; address and data held stable until axi_ack.
REQ-007 axi_we  in  1  1 = write, 0 = read.
REQ-008 axi_addr  in  ADDR_W  word address.
REQ-009 axi_wdata  in  32  write data.
REQ-010 axi_wstrb  in  4  byte enables.
REQ-011 axi_ack  out  1  one-cycle pulse; request accepted this cycle.
REQ-012 axi_rvalid  out  1  one-cycle pulse; axi_rdata valid.
REQ-013 axi_rdata  out  32  read data.
REQ-014 axi_err  out  1  pulses with axi_ack when axi_addr >= DEPTH.
REQ-015 vid_req  in  1  glyph-fetch read request; vid_addr held until vid_ack.
REQ-016 vid_addr  in  ADDR_W  word address.
REQ-017 vid_ack  out  1  one-cycle pulse; fetch accepted.
REQ-018 vid_rvalid  out  1  one-cycle pulse; vid_rdata valid.
REQ-019 vid_rdata  out  32  read data.
REQ-020 bram_en, bram_we[3:0], bram_addr[ADDR_W], bram_din[32]  out  single-port BRAM command.
REQ-021 bram_dout  in  32  BRAM read data, latency RD_LAT = 2 cycles after bram_en.

Function
REQ-022 At most one BRAM access per cycle; grant and ack are combinational in the request cycle N; bram_en asserts in cycle N.
REQ-023 Arbiter FSM states: VID_PRI (video wins ties) and AXI_TURN (AXI wins ties); a lone requester is always granted.
REQ-024 A 3-bit starve counter increments on each video grant while axi_req is pending, and clears on any AXI grant or when axi_req is low.
REQ-025 When the counter reaches STARVE_LIMIT, the FSM moves VID_PRI->AXI_TURN; after one AXI grant it returns to VID_PRI.
REQ-026 bram_we = axi_wstrb on an AXI write grant, otherwise 0; a write produces no rvalid.
REQ-027 Every granted read enters a 2-stage tag pipeline (valid, owner); the owner's rvalid pulses in cycle N+2 with bram_dout routed to its rdata.
REQ-028 An AXI access with addr >= DEPTH is acked with axi_err and no bram_en; if it is a read, axi_rvalid pulses at N+2 with axi_rdata = 0.
REQ-029 Back-to-back grants are legal every cycle; rvalid pulses keep grant order with no bubbles.
REQ-030 axi_rdata and vid_rdata hold their last value when rvalid is low.

Reset
REQ-031 On S_AXI_ARESETN=0: FSM=VID_PRI, counter=0, tag pipeline cleared, all ack/rvalid/err/bram_en/bram_we = 0, rdata = 0.
REQ-032 Reads in flight at reset are dropped; no rvalid pulses in the two cycles after reset release.

Configuration
REQ-033 Macro VRAM_ARB_STARVE_GUARD_EN: when defined, REQ-024/025 apply; when undefined, the FSM stays in VID_PRI (strict video priority) and the counter is not built.

Structure
REQ-034 Package vram_pkg holds RD_LAT, the owner enum (OWN_AXI, OWN_VID), the FSM state enum, and the tag struct.
REQ-035 Sub-module vram_rd_tag_pipe implements the RD_LAT-deep tag shift register; all other logic is flat.

Verification
REQ-036 Simultaneous vid_req and axi_req read from reset -> vid_ack in cycle 0, axi_ack in cycle 1; vid_rvalid at cycle 2, axi_rvalid at cycle 3.
REQ-037 AXI write addr 5, data 0xDEADBEEF, wstrb 0x3, then read addr 5 (BRAM initialised to 0) -> read returns 0x0000BEEF; no rvalid for the write.
REQ-038 vid_req held high continuously with axi_req pending, STARVE_LIMIT=4 -> axi_ack on the 5th cycle; with the macro undefined -> no axi_ack while vid_req is high.
REQ-039 AXI read addr 601 -> axi_ack and axi_err in the same cycle, bram_en=0, axi_rvalid 2 cycles later with axi_rdata 0.
REQ-040 Reset asserted one cycle after a vid read grant -> vid_rvalid never pulses, and all outputs are 0 during reset.
